// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU control encodings, operand-source selects and MIPS opcode/funct constants.
// Imported by the ALU and by the ID/EX decode stage.
package alu_decode_stage_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    SEL_SHIFT = 2'd0,
    SEL_SLT   = 2'd1,
    SEL_ARITH = 2'd2,
    SEL_LOGIC = 2'd3
  } alu_sel_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROR = 2'd3
  } alu_shift_e;

  typedef enum logic {
    AR_ADD = 1'b0,
    AR_SUB = 1'b1
  } alu_arith_e;

  typedef enum logic [1:0] {
    LG_AND = 2'd0,
    LG_OR  = 2'd1,
    LG_NOR = 2'd2,
    LG_XOR = 2'd3
  } alu_logic_e;

  typedef enum logic [1:0] {
    OP1_RS  = 2'd0,
    OP1_SA  = 2'd1,
    OP1_C16 = 2'd2
  } op1_src_e;

  typedef enum logic [1:0] {
    OP2_RT   = 2'd0,
    OP2_SIMM = 2'd1,
    OP2_ZIMM = 2'd2
  } op2_src_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_shift_e shift_op;
    alu_arith_e arith_op;
    alu_logic_e logic_op;
    alu_sel_e   select;
    logic       sign;
    op1_src_e   op1_src;
    op2_src_e   op2_src;
    logic       ovf_en;
    logic       illegal;
  } alu_ctrl_t;

  // Base bundle for any recognised instruction: everything 0 except signed compare.
  function automatic alu_ctrl_t ctrl_base();
    alu_ctrl_t c;
    c          = '0;
    c.sign     = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / ALU-control-out bundle between the ID stage and the decode register.
import alu_decode_stage_pkg::*;

interface alu_decode_stage_if;
  logic               i_valid;
  logic [INSTR_W-1:0] i_instr;
  logic               i_stall;
  logic               i_flush;
  logic               o_valid;
  logic [1:0]         o_shift_op;
  logic               o_arith_op;
  logic [1:0]         o_logic_op;
  logic [1:0]         o_select;
  logic               o_sign;
  logic [1:0]         o_op1_src;
  logic [1:0]         o_op2_src;
  logic               o_ovf_en;
  logic               o_illegal;

  modport master (
    output i_valid, i_instr, i_stall, i_flush,
    input  o_valid, o_shift_op, o_arith_op, o_logic_op, o_select,
           o_sign, o_op1_src, o_op2_src, o_ovf_en, o_illegal
  );

  modport slave (
    input  i_valid, i_instr, i_stall, i_flush,
    output o_valid, o_shift_op, o_arith_op, o_logic_op, o_select,
           o_sign, o_op1_src, o_op2_src, o_ovf_en, o_illegal
  );
endinterface

// File: rtl/alu_decode_comb.sv
// Purely combinational MIPS instruction -> ALU control bundle decode.
import alu_decode_stage_pkg::*;

module alu_decode_comb #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] instr_i,
  output alu_ctrl_t        ctrl_o
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_bits_s;

  assign opcode_s      = instr_i[31:26];
  assign funct_s       = instr_i[5:0];
  assign unused_bits_s = ^{instr_i[25:22], instr_i[20:7]};

  // Decode opcode/funct; unknown encodings fall back to a harmless ADD bundle.
  always_comb begin
    ctrl_o = ctrl_base();
    if (opcode_s == OPC_RTYPE) begin
      case (funct_s)
        FN_SLL:  ctrl_o.op1_src = OP1_SA;
        FN_SLLV: ctrl_o.shift_op = SH_SLL;
        FN_SRL: begin
          ctrl_o.shift_op = instr_i[21] ? SH_ROR : SH_SRL;
          ctrl_o.op1_src  = OP1_SA;
        end
        FN_SRLV: ctrl_o.shift_op = instr_i[6] ? SH_ROR : SH_SRL;
        FN_SRA: begin
          ctrl_o.shift_op = SH_SRA;
          ctrl_o.op1_src  = OP1_SA;
        end
        FN_SRAV: ctrl_o.shift_op = SH_SRA;
        FN_ADD, FN_ADDU: begin
          ctrl_o.select = SEL_ARITH;
          ctrl_o.ovf_en = (funct_s == FN_ADD);
        end
        FN_SUB, FN_SUBU: begin
          ctrl_o.select   = SEL_ARITH;
          ctrl_o.arith_op = AR_SUB;
          ctrl_o.ovf_en   = (funct_s == FN_SUB);
        end
        FN_AND: ctrl_o.select = SEL_LOGIC;
        FN_OR: begin
          ctrl_o.select   = SEL_LOGIC;
          ctrl_o.logic_op = LG_OR;
        end
        FN_XOR: begin
          ctrl_o.select   = SEL_LOGIC;
          ctrl_o.logic_op = LG_XOR;
        end
        FN_NOR: begin
          ctrl_o.select   = SEL_LOGIC;
          ctrl_o.logic_op = LG_NOR;
        end
        FN_SLT, FN_SLTU: begin
          ctrl_o.select   = SEL_SLT;
          ctrl_o.arith_op = AR_SUB;
          ctrl_o.sign     = (funct_s == FN_SLT);
        end
        default: begin
          ctrl_o.select  = SEL_ARITH;
          ctrl_o.illegal = 1'b1;
        end
      endcase
    end else begin
      case (opcode_s)
        OPC_ADDI, OPC_ADDIU: begin
          ctrl_o.select  = SEL_ARITH;
          ctrl_o.op2_src = OP2_SIMM;
          ctrl_o.ovf_en  = (opcode_s == OPC_ADDI);
        end
        OPC_SLTI, OPC_SLTIU: begin
          ctrl_o.select   = SEL_SLT;
          ctrl_o.arith_op = AR_SUB;
          ctrl_o.op2_src  = OP2_SIMM;
          ctrl_o.sign     = (opcode_s == OPC_SLTI);
        end
        OPC_ANDI: begin
          ctrl_o.select  = SEL_LOGIC;
          ctrl_o.op2_src = OP2_ZIMM;
        end
        OPC_ORI: begin
          ctrl_o.select   = SEL_LOGIC;
          ctrl_o.logic_op = LG_OR;
          ctrl_o.op2_src  = OP2_ZIMM;
        end
        OPC_XORI: begin
          ctrl_o.select   = SEL_LOGIC;
          ctrl_o.logic_op = LG_XOR;
          ctrl_o.op2_src  = OP2_ZIMM;
        end
        // LUI is imm16 << 16, so operand 1 is the constant shift amount.
        OPC_LUI: begin
          ctrl_o.op1_src = OP1_C16;
          ctrl_o.op2_src = OP2_ZIMM;
        end
        OPC_LW, OPC_SW: begin
          ctrl_o.select  = SEL_ARITH;
          ctrl_o.op2_src = OP2_SIMM;
        end
        OPC_BEQ, OPC_BNE: begin
          ctrl_o.select   = SEL_ARITH;
          ctrl_o.arith_op = AR_SUB;
        end
        default: begin
          ctrl_o.select  = SEL_ARITH;
          ctrl_o.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX ALU-control register: decodes the instruction and holds it with stall/flush control.
import alu_decode_stage_pkg::*;

module alu_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_decode_stage_if.slave  bus
);

  alu_ctrl_t dec_s;
  alu_ctrl_t ctrl_d;
  alu_ctrl_t ctrl_q;
  logic      valid_d;
  logic      valid_q;

  alu_decode_comb #(.WIDTH(WIDTH)) u_decode (
    .instr_i (bus.i_instr),
    .ctrl_o  (dec_s)
  );

  // Next-state: flush beats stall, stall beats load.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (bus.i_flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (bus.i_stall) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else begin
      ctrl_d  = dec_s;
      valid_d = bus.i_valid;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_shift_op = ctrl_q.shift_op;
  assign bus.o_arith_op = ctrl_q.arith_op;
  assign bus.o_logic_op = ctrl_q.logic_op;
  assign bus.o_select   = ctrl_q.select;
  assign bus.o_sign     = ctrl_q.sign;
  assign bus.o_op1_src  = ctrl_q.op1_src;
  assign bus.o_op2_src  = ctrl_q.op2_src;
  assign bus.o_ovf_en   = ctrl_q.ovf_en;
  assign bus.o_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomised bench for alu_decode_stage against an instruction-level reference model.
module tb_alu_decode_stage;

  typedef struct {
    int vld;
    int shift;
    int arith;
    int lg;
    int sel;
    int sign;
    int op1;
    int op2;
    int ovf;
    int ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_decode_stage_if bus ();

  alu_decode_stage #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp[31:0]) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Reference decode written from the instruction table.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    int lgmap_r[4];
    int lgmap_i[3];
    lgmap_r = '{0, 1, 3, 2};
    lgmap_i = '{0, 1, 3};
    op = w[31:26];
    fn = w[5:0];
    e = zero_exp();
    e.sign = 1;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
        e.op1 = (fn < 6'h04) ? 1 : 0;
        if (fn[1:0] == 2'd0)      e.shift = 0;
        else if (fn[1:0] == 2'd3) e.shift = 2;
        else if (fn < 6'h04)      e.shift = w[21] ? 3 : 1;
        else                      e.shift = w[6] ? 3 : 1;
      end else if (fn inside {[6'h20:6'h23]}) begin
        e.sel = 2;
        e.arith = (fn >= 6'h22) ? 1 : 0;
        e.ovf = (fn == 6'h20 || fn == 6'h22) ? 1 : 0;
      end else if (fn inside {[6'h24:6'h27]}) begin
        e.sel = 3;
        e.lg = lgmap_r[int'(fn) - 36];
      end else if (fn == 6'h2A || fn == 6'h2B) begin
        e.sel = 1;
        e.arith = 1;
        e.sign = (fn == 6'h2A) ? 1 : 0;
      end else begin
        e.sel = 2;
        e.ill = 1;
      end
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) begin
      e.sel = 2;
      e.op2 = 1;
      e.ovf = (op == 6'h08) ? 1 : 0;
    end else if (op == 6'h0A || op == 6'h0B) begin
      e.sel = 1;
      e.arith = 1;
      e.op2 = 1;
      e.sign = (op == 6'h0A) ? 1 : 0;
    end else if (op inside {[6'h0C:6'h0E]}) begin
      e.sel = 3;
      e.op2 = 2;
      e.lg = lgmap_i[int'(op) - 12];
    end else if (op == 6'h0F) begin
      e.op1 = 2;
      e.op2 = 2;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.sel = 2;
      e.arith = 1;
    end else begin
      e.sel = 2;
      e.ill = 1;
    end
    return e;
  endfunction

  // Compare process: advance the cycle model at each edge, then check every output.
  initial begin
    exp_t m;
    logic s_rst, s_v, s_st, s_fl;
    logic [31:0] s_ins;
    m = zero_exp();
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_v   = bus.i_valid;
      s_st  = bus.i_stall;
      s_fl  = bus.i_flush;
      s_ins = bus.i_instr;
      #1;
      if (s_rst === 1'b1 || s_fl === 1'b1) begin
        m = zero_exp();
      end else if (s_st !== 1'b1) begin
        m = ref_decode(s_ins);
        m.vld = s_v ? 1 : 0;
      end
      chk("cyc_valid", {31'd0, bus.o_valid},  m.vld);
      chk("cyc_shift", {30'd0, bus.o_shift_op}, m.shift);
      chk("cyc_arith", {31'd0, bus.o_arith_op}, m.arith);
      chk("cyc_logic", {30'd0, bus.o_logic_op}, m.lg);
      chk("cyc_select", {30'd0, bus.o_select}, m.sel);
      chk("cyc_sign", {31'd0, bus.o_sign},    m.sign);
      chk("cyc_op1", {30'd0, bus.o_op1_src},  m.op1);
      chk("cyc_op2", {30'd0, bus.o_op2_src},  m.op2);
      chk("cyc_ovf", {31'd0, bus.o_ovf_en},   m.ovf);
      chk("cyc_illegal", {31'd0, bus.o_illegal}, m.ill);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_instr = ins;
    bus.i_stall = st;
    bus.i_flush = fl;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns[16];
    logic [5:0] ops[14];
    logic [31:0] w;
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    ops = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01};
    w = $urandom;
    if ($urandom_range(0, 9) < 5) begin
      w[31:26] = 6'h00;
      if ($urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 15)];
    end else if ($urandom_range(0, 7) != 0) begin
      w[31:26] = ops[$urandom_range(0, 13)];
    end
    return w;
  endfunction

  initial begin
    exp_t p;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instr = 32'd0;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 0);
    chk("rst_select", {30'd0, bus.o_select}, 0);
    chk("rst_sign", {31'd0, bus.o_sign}, 0);
    chk("rst_illegal", {31'd0, bus.o_illegal}, 0);

    p = ref_decode(32'h00221821);
    chk("pin_addu_sel", p.sel, 2);
    chk("pin_addu_ovf", p.ovf, 0);
    p = ref_decode(32'h00000027);
    chk("pin_nor_logic", p.lg, 2);
    p = ref_decode(32'h2C22000A);
    chk("pin_sltiu_sign", p.sign, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h00221821, 1'b0, 1'b0);
    chk("addu_valid", {31'd0, bus.o_valid}, 1);
    chk("addu_select", {30'd0, bus.o_select}, 2);
    chk("addu_sign", {31'd0, bus.o_sign}, 1);
    chk("addu_ovf", {31'd0, bus.o_ovf_en}, 0);
    drive(1'b1, 32'h2C22000A, 1'b0, 1'b0);
    chk("sltiu_select", {30'd0, bus.o_select}, 1);
    chk("sltiu_arith", {31'd0, bus.o_arith_op}, 1);
    chk("sltiu_sign", {31'd0, bus.o_sign}, 0);
    chk("sltiu_op2", {30'd0, bus.o_op2_src}, 1);
    drive(1'b1, 32'h2822000A, 1'b0, 1'b0);
    chk("slti_sign", {31'd0, bus.o_sign}, 1);
    drive(1'b1, 32'h00200902, 1'b0, 1'b0);
    chk("ror_shift", {30'd0, bus.o_shift_op}, 3);
    chk("ror_op1", {30'd0, bus.o_op1_src}, 1);
    drive(1'b1, 32'h00000902, 1'b0, 1'b0);
    chk("srl_shift", {30'd0, bus.o_shift_op}, 1);
    drive(1'b1, 32'h3C011234, 1'b0, 1'b0);
    chk("lui_select", {30'd0, bus.o_select}, 0);
    chk("lui_op1", {30'd0, bus.o_op1_src}, 2);
    chk("lui_op2", {30'd0, bus.o_op2_src}, 2);
    drive(1'b1, 32'hFC000000, 1'b0, 1'b0);
    chk("ill_flag", {31'd0, bus.o_illegal}, 1);
    chk("ill_select", {30'd0, bus.o_select}, 2);
    drive(1'b0, 32'h00221820, 1'b0, 1'b0);
    chk("novalid_valid", {31'd0, bus.o_valid}, 0);

    drive(1'b1, 32'h00221820, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00221822, 1'b1, 1'b0);
      chk("stall_arith", {31'd0, bus.o_arith_op}, 0);
      chk("stall_ovf", {31'd0, bus.o_ovf_en}, 1);
    end
    drive(1'b1, 32'h00221822, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, bus.o_valid}, 0);
    chk("flush_sign", {31'd0, bus.o_sign}, 0);
    drive(1'b1, 32'h00221822, 1'b0, 1'b0);
    chk("release_arith", {31'd0, bus.o_arith_op}, 1);
    chk("release_valid", {31'd0, bus.o_valid}, 1);

    drive(1'b1, 32'h00221820, 1'b0, 1'b0);
    drive(1'b1, 32'h00221822, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.o_valid}, 0);
    chk("arst_ovf", {31'd0, bus.o_ovf_en}, 0);
    chk("arst_select", {30'd0, bus.o_select}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_stall = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_arith", {31'd0, bus.o_arith_op}, 1);
    chk("post_rst_valid", {31'd0, bus.o_valid}, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_instr = rand_instr();
      bus.i_stall = ($urandom_range(0, 4) == 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
